mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage directly downstream of the execute stage. Takes the ALU result as the effective address and the second register operand as store data, performs one load or store per instruction over a req/ack data-memory handshake, and returns aligned, sign- or zero-extended load data to writeback. Holds the upstream pipeline with `stall` while an access is outstanding.

## Interface
- `XLEN`, default 32: data/address width; only 32 is supported.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ALU_out`  in  XLEN: effective address from execute.
- `DataB`  in  XLEN: store data from execute.
- `MemEn`  in  1: instruction in this stage is a load or store.
- `MemRW`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: bits [1:0] select size (00 byte, 01 half, 1x word); bit [2] = unsigned load.
- `dmem_req`  out  1: request valid to data memory.
- `dmem_we`  out  1: request is a write.
- `dmem_addr`  out  XLEN: word-aligned address, {ALU_out[31:2], 2'b00}.
- `dmem_wdata`  out  XLEN: byte-replicated store data.
- `dmem_be`  out  4: byte enables.
- `dmem_ack`  in  1: memory completes the request this cycle.
- `dmem_rdata`  in  XLEN: read word, valid when `dmem_ack` is high.
- `stall`  out  1: hold all upstream stages.
- `load_data`  out  XLEN: extended load result.
- `load_valid`  out  1: one-cycle pulse, `load_data` valid.
- `misalign`  out  1: misaligned-access pulse (see Configuration).

## Operation
- FSM states: IDLE, WAIT.
- IDLE: if `MemEn`=1 (and access not trapped), register address, wdata, be, we, size, sign, byte offset; go to WAIT.
- WAIT: `dmem_req`=1 with all request fields stable. On `dmem_ack`=1: for loads register `load_data`, pulse `load_valid`; go to IDLE. Stores produce no `load_valid`.
- `stall` (combinational) = (IDLE & `MemEn` & not trapped) | WAIT; forced 0 while `rst_n`=0.
- Byte: be = 4'b0001 << off; wdata = {4{DataB[7:0]}}. Half: be = 4'b0011 << {off[1],1'b0}; wdata = {2{DataB[15:0]}}. Word: be = 4'b1111; wdata = DataB.
- Load: shift rdata right by 8*off (half uses {off[1],0}, word uses 0); extend bit 7/15 when funct3[2]=0, zero-extend when 1.
- `MemEn` in WAIT is ignored. `dmem_ack` in IDLE is ignored.
- Reset mid-access: state → IDLE, `dmem_req` low at the next edge; any later ack is ignored.
- Reset values: every output 0, state IDLE.

## Timing
- Cycle 0: `MemEn`=1 in IDLE, `stall`=1.
- Cycle 1: `dmem_req`=1. Ack earliest in cycle 1.
- Ack in cycle k: `load_valid`=1 and `load_data` valid in cycle k+1; `dmem_req`=0 and `stall`=0 in cycle k+1.
- Minimum occupancy: 2 cycles of stall for a zero-wait memory. Back-to-back accesses: new `MemEn` accepted in cycle k+1.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: half with off[0]=1 or word with off≠0 issues no request, asserts no stall, and pulses `misalign` for exactly one cycle (cycle 1). No `load_valid`.
- Undefined: `misalign` tied 0. Misaligned accesses are performed with the offset truncated (half uses off[1], word uses no offset).

## Test plan
- LW, ALU_out=0x100, ack in cycle 1, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, load_valid cycle 2, load_data=0xDEADBEEF, stall cycles 0–1.
- LB at 0x103, rdata=0x80FF_0000 → load_data=0xFFFFFF80. LBU same access → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x201, DataB=0x12345678, ack after 3 wait cycles → dmem_we=1, be=0010, wdata=0x78787878 held stable until ack; no load_valid; stall low the cycle after ack.
- rst_n low during WAIT, then ack arrives → dmem_req 0 next edge, load_valid stays 0, all outputs 0.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x102 → no dmem_req, stall 0, misalign=1 for one cycle. Without the macro, same access → dmem_addr=0x100, be=1111, normal completion.
- Two back-to-back loads with zero-wait ack → second request in cycle 3, both load_valid pulses with correct data.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage sitting directly after execute. The ALU result
// is the effective address and DataB is the store data. Each load or store is
// issued as one request on the data-memory req/ack handshake. Load data comes
// back aligned and sign- or zero-extended for writeback. While an access is
// outstanding, the upstream pipeline is held with `stall`.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are not issued. They raise a
//               one-cycle `misalign` pulse and do not stall.
//   undefined : `misalign` is tied 0. Misaligned accesses are performed with
//               the offset truncated to the natural alignment.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ALU_out   [XLEN]      effective address from execute
//   DataB     [XLEN]      store data from execute
//   MemEn, MemRW          access present / 1 = store, 0 = load
//   funct3    [3]         [1:0] size (00 byte, 01 half, 1x word), [2] unsigned
//   dmem_req, dmem_we     request valid / request is a write
//   dmem_addr [XLEN]      word-aligned address
//   dmem_wdata[XLEN]      byte-replicated store data
//   dmem_be   [4]         byte enables
//   dmem_ack              memory completes the request this cycle
//   dmem_rdata[XLEN]      read word, valid with dmem_ack
//   stall                 hold all upstream stages
//   load_data [XLEN]      extended load result
//   load_valid            one-cycle pulse, load_data valid
//   misalign              one-cycle misaligned-access pulse
//   dbg_state             current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: dmem_req rises the cycle after an access is accepted. It stays
// high, with dmem_addr/dmem_we/dmem_be/dmem_wdata frozen, up to and including
// the cycle in which dmem_ack is sampled high. The request completes at that
// clock edge, and dmem_req is low in the following cycle. An ack seen while
// dmem_req is low is ignored.
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ALU_out,
    input  logic [XLEN-1:0] DataB,
    input  logic            MemEn,
    input  logic            MemRW,
    input  logic [2:0]      funct3,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misalign,
    output logic            dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request decode from the execute-stage operands
    logic [1:0]      off;
    logic [1:0]      eff_off;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic            trapped;
    logic            accept;

    // Captured access attributes needed when the read data returns
    logic [1:0]      size_q;
    logic            uns_q;
    logic [1:0]      off_q;

    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ext_data;
    logic            done_load;

    assign off = ALU_out[1:0];

    // A half access keeps only off[1], and a word access keeps no offset.
    // Without the trap, this truncation is also how misaligned accesses are
    // performed.
    always_comb begin
        eff_off = 2'b00;
        be_d    = 4'b1111;
        wdata_d = DataB;
        if (funct3[1]) begin
            eff_off = 2'b00;
            be_d    = 4'b1111;
            wdata_d = DataB;
        end else if (funct3[0]) begin
            eff_off = {off[1], 1'b0};
            be_d    = 4'b0011 << {off[1], 1'b0};
            wdata_d = {2{DataB[15:0]}};
        end else begin
            eff_off = off;
            be_d    = 4'b0001 << off;
            wdata_d = {4{DataB[7:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_acc;
    assign misaligned_acc = (funct3[1] && (off != 2'b00)) ||
                            (!funct3[1] && funct3[0] && off[0]);
    assign trapped = MemEn && misaligned_acc;
`else
    assign trapped = 1'b0;
`endif

    assign accept = (state_q == IDLE) && MemEn && !trapped;

    // Combinational stall. The current-cycle acceptance is included so that
    // upstream holds in cycle 0. Stall is forced low while reset is asserted.
    assign stall = rst_n && (accept || (state_q == WAIT));

    assign dmem_req  = (state_q == WAIT);
    assign dbg_state = state_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: if (dmem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load alignment and extension
    assign rshift    = dmem_rdata >> {off_q, 3'b000};
    assign done_load = (state_q == WAIT) && dmem_ack && !dmem_we;

    always_comb begin
        ext_data = dmem_rdata;
        case (size_q)
            2'b00:   ext_data = {{(XLEN-8){!uns_q && rshift[7]}}, rshift[7:0]};
            2'b01:   ext_data = {{(XLEN-16){!uns_q && rshift[15]}}, rshift[15:0]};
            default: ext_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= 4'b0000;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_valid <= done_load;
            if (done_load) begin
                load_data <= ext_data;
            end
            if (accept) begin
                dmem_we    <= MemRW;
                dmem_addr  <= {ALU_out[XLEN-1:2], 2'b00};
                dmem_wdata <= wdata_d;
                dmem_be    <= be_d;
                size_q     <= funct3[1] ? 2'b10 : {1'b0, funct3[0]};
                uns_q      <= funct3[2];
                off_q      <= eff_off;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Trapped accesses are only recognised in IDLE. The pulse lands in the
    // cycle after the offending instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state_q == IDLE) && trapped;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALU_out;
    logic [31:0] DataB;
    logic        MemEn;
    logic        MemRW;
    logic [2:0]  funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        dbg_state;

    mem_access_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALU_out    (ALU_out),
        .DataB      (DataB),
        .MemEn      (MemEn),
        .MemRW      (MemRW),
        .funct3     (funct3),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    bit          exp_lv;
    bit          exp_mis;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_nbytes(input logic [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    // Byte offset actually used: natural alignment truncates the low bits.
    function automatic int ref_off(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = ref_nbytes(f3);
        return (int'(addr[1:0]) / n) * n;
    endfunction

    function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
        return (int'(addr[1:0]) % ref_nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = ref_nbytes(f3);
        return 4'(((1 << n) - 1) << ref_off(f3, addr));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = ref_nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v;
        longint span;
        int     n;
        n    = ref_nbytes(f3);
        span = longint'(1) << (8 * n);
        v    = (longint'(rd) >> (8 * ref_off(f3, addr))) % span;
        if (!f3[2] && (v >= span / 2)) v = v - span;
        return v[31:0];
    endfunction

    // Checks common to every sampled cycle: pending load result and misalign pulse.
    task automatic sample_common();
        logic [31:0] e;
        check("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
        if (exp_lv) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("load_data", load_data, e);
            end else begin
                check("exp_q_underflow", 32'd1, 32'd0);
            end
        end
        check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
        exp_lv  = 1'b0;
        exp_mis = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        @(negedge clk);
        MemEn      = 1'b0;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        sample_common();
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_req", {31'd0, dmem_req}, 32'd0);
    endtask

    task automatic do_access(input logic [31:0] addr, input logic [31:0] d, input logic rw,
                             input logic [2:0] f3, input int nwait, input logic [31:0] rd);
        // cycle 0: present the instruction; a stray ack here must be ignored
        @(negedge clk);
        ALU_out    = addr;
        DataB      = d;
        MemRW      = rw;
        funct3     = f3;
        MemEn      = 1'b1;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        sample_common();
        check("c0_req", {31'd0, dmem_req}, 32'd0);
        if (ref_trap(f3, addr)) begin
            check("trap_stall", {31'd0, stall}, 32'd0);
            exp_mis = 1'b1;
            return;
        end
        check("c0_stall", {31'd0, stall}, 32'd1);
        // wait cycles and the ack cycle; upstream inputs wander and must be ignored
        for (int w = 0; w <= nwait; w++) begin
            @(negedge clk);
            MemEn      = 1'($urandom_range(0, 1));
            ALU_out    = $urandom;
            DataB      = $urandom;
            MemRW      = 1'($urandom_range(0, 1));
            funct3     = 3'($urandom_range(0, 7));
            dmem_ack   = (w == nwait);
            dmem_rdata = (w == nwait) ? rd : $urandom;
            #1;
            sample_common();
            check("req", {31'd0, dmem_req}, 32'd1);
            check("we", {31'd0, dmem_we}, {31'd0, rw});
            check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("be", {28'd0, dmem_be}, {28'd0, ref_be(f3, addr)});
            if (rw) check("wdata", dmem_wdata, ref_wdata(f3, d));
            check("wait_stall", {31'd0, stall}, 32'd1);
        end
        if (!rw) begin
            exp_lv = 1'b1;
            exp_q.push_back(ref_load(f3, addr, rd));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total      = 0;
        bad        = 0;
        exp_lv     = 1'b0;
        exp_mis    = 1'b0;
        rst_n      = 1'b0;
        ALU_out    = 32'd0;
        DataB      = 32'd0;
        MemEn      = 1'b1;
        MemRW      = 1'b0;
        funct3     = 3'b010;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;

        // reset with MemEn high: stall must still be forced low
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        MemEn = 1'b0;
        idle_cycle();

        // directed cases
        do_access(32'h0000_0100, 32'h0, 1'b0, 3'b010, 0, 32'hDEAD_BEEF);  // LW
        idle_cycle();
        do_access(32'h0000_0103, 32'h0, 1'b0, 3'b000, 0, 32'h80FF_0000);  // LB
        idle_cycle();
        do_access(32'h0000_0103, 32'h0, 1'b0, 3'b100, 1, 32'h80FF_0000);  // LBU
        idle_cycle();
        do_access(32'h0000_0102, 32'h0, 1'b0, 3'b001, 2, 32'h80FF_0000);  // LH
        idle_cycle();
        do_access(32'h0000_0201, 32'h1234_5678, 1'b1, 3'b000, 3, 32'h0);  // SB
        idle_cycle();
        do_access(32'h0000_0102, 32'h0, 1'b0, 3'b010, 0, 32'hCAFE_F00D);  // misaligned LW
        idle_cycle();
        // back-to-back zero-wait loads
        do_access(32'h0000_0300, 32'h0, 1'b0, 3'b010, 0, 32'h1111_2222);
        do_access(32'h0000_0306, 32'h0, 1'b0, 3'b101, 0, 32'h9876_5432);
        idle_cycle();

        // reset during WAIT; the late ack must be ignored
        @(negedge clk);
        ALU_out = 32'h0000_0104;
        MemRW   = 1'b0;
        funct3  = 3'b010;
        MemEn   = 1'b1;
        dmem_ack = 1'b0;
        #1;
        check("mr_c0_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        MemEn = 1'b0;
        #1;
        check("mr_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_stall_forced", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("mr_req_cleared", {31'd0, dmem_req}, 32'd0);
        check("mr_addr", dmem_addr, 32'd0);
        check("mr_be", {28'd0, dmem_be}, 32'd0);
        check("mr_state", {31'd0, dbg_state}, 32'd0);
        check("mr_load_valid", {31'd0, load_valid}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hA5A5_A5A5;
        #1;
        check("mr_late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("mr_late_ack_stall", {31'd0, stall}, 32'd0);
        idle_cycle();

        // randomized accesses
        for (int i = 0; i < 200; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            do_access($urandom, $urandom, 1'($urandom_range(0, 1)), f3,
                      $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
